// File: rtl/bomb_catch_scorer.sv
// Catch/miss scorer for the falling-bomb game.
// Each frame the bomb position is compared against the player box. This block
// keeps the caught-bomb count, which feeds the bomb's speed-up control. It also
// keeps the remaining lives and a game-over flag.
//
// Ports:
//   frame_clk   - frame-rate clock, one rising edge per video frame
//   Reset       - asynchronous, active-high reset
//   bombX/bombY - bomb centre position
//   playerX/Y   - player centre position
//   keycode     - current keyboard code (RESTART_KEY restarts after game over)
//   curPoints   - caught-bomb count, saturating at MAX_POINTS
//   lives       - remaining lives
//   game_over   - high while the game is over
//   catch_pulse - one-frame pulse on a catch
//   miss_pulse  - one-frame pulse on a miss
module bomb_catch_scorer #(
   parameter int unsigned BOMB_HALF     = 4,
   parameter int unsigned PLAYER_HALF_W = 16,
   parameter int unsigned PLAYER_HALF_H = 8,
   parameter int unsigned Y_FLOOR       = 479,
   parameter int unsigned MAX_POINTS    = 9,
   parameter int unsigned START_LIVES   = 3,
   parameter logic [7:0]  RESTART_KEY   = 8'h28
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [9:0] bombX,
   input  logic [9:0] bombY,
   input  logic [9:0] playerX,
   input  logic [9:0] playerY,
   input  logic [7:0] keycode,
   output logic [3:0] curPoints,
   output logic [1:0] lives,
   output logic       game_over,
   output logic       catch_pulse,
   output logic       miss_pulse
);

   localparam logic [10:0] ReachX   = 11'(BOMB_HALF + PLAYER_HALF_W);
   localparam logic [10:0] ReachY   = 11'(BOMB_HALF + PLAYER_HALF_H);
   localparam logic [9:0]  FloorY   = 10'(Y_FLOOR);
   localparam logic [3:0]  MaxPts   = 4'(MAX_POINTS);
   localparam logic [1:0]  StartLiv = 2'(START_LIVES);

   typedef enum logic [1:0] {StArmed = 2'd0, StWait = 2'd1, StOver = 2'd2} state_e;

   state_e      state_q, state_d;
   logic [3:0]  points_q, points_d;
   logic [1:0]  lives_q, lives_d;
   logic        over_q, over_d;
   logic        catch_q, catch_d;
   logic        miss_q, miss_d;
   logic [9:0]  bomb_y_prev_q;

   // Zero-extended 11-bit signed differences avoid unsigned wrap near the edges.
   logic signed [10:0] dx, dy;
   logic        [10:0] abs_dx, abs_dy;
   logic               overlap, landed, respawn, restart;

   always_comb begin
      dx      = $signed({1'b0, bombX}) - $signed({1'b0, playerX});
      dy      = $signed({1'b0, bombY}) - $signed({1'b0, playerY});
      abs_dx  = dx[10] ? 11'(-dx) : 11'(dx);
      abs_dy  = dy[10] ? 11'(-dy) : 11'(dy);
      overlap = (abs_dx <= ReachX) && (abs_dy <= ReachY);
      landed  = (bombY >= FloorY);
      // Bomb jumped back up to its spawn row.
      respawn = (bombY < bomb_y_prev_q);
      restart = (keycode == RESTART_KEY);
   end

   // State register and registered outputs.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q       <= StArmed;
         points_q      <= 4'd0;
         lives_q       <= StartLiv;
         over_q        <= 1'b0;
         catch_q       <= 1'b0;
         miss_q        <= 1'b0;
         bomb_y_prev_q <= 10'd0;
      end else begin
         state_q       <= state_d;
         points_q      <= points_d;
         lives_q       <= lives_d;
         over_q        <= over_d;
         catch_q       <= catch_d;
         miss_q        <= miss_d;
         bomb_y_prev_q <= bombY;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StArmed: begin
            if (overlap) begin
               state_d = StWait;
            end else if (landed) begin
               state_d = (lives_q <= 2'd1) ? StOver : StWait;
            end
         end
         StWait: begin
            if (respawn) state_d = StArmed;
         end
         StOver: begin
            // Restart into WAIT so the drop already in flight is not scored.
            if (restart) state_d = StWait;
         end
         default: state_d = StArmed;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      points_d = points_q;
      lives_d  = lives_q;
      over_d   = over_q;
      catch_d  = 1'b0;
      miss_d   = 1'b0;
      case (state_q)
         StArmed: begin
            // Catch wins over a same-edge landing; lives untouched then.
            if (overlap) begin
               catch_d  = 1'b1;
               points_d = (points_q >= MaxPts) ? MaxPts : points_q + 4'd1;
            end else if (landed) begin
               miss_d  = 1'b1;
               lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
               if (lives_q <= 2'd1) over_d = 1'b1;
            end
         end
         StOver: begin
            if (restart) begin
               points_d = 4'd0;
               lives_d  = StartLiv;
               over_d   = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign curPoints   = points_q;
   assign lives       = lives_q;
   assign game_over   = over_q;
   assign catch_pulse = catch_q;
   assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_bomb_catch_scorer.sv
// Directed testbench for bomb_catch_scorer with hand-computed expectations.
module tb_bomb_catch_scorer;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [9:0] bombX, bombY, playerX, playerY;
   logic [7:0] keycode;
   logic [3:0] curPoints;
   logic [1:0] lives;
   logic       game_over, catch_pulse, miss_pulse;

   int errors = 0;
   int checks = 0;

   bomb_catch_scorer dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .bombX       (bombX),
      .bombY       (bombY),
      .playerX     (playerX),
      .playerY     (playerY),
      .keycode     (keycode),
      .curPoints   (curPoints),
      .lives       (lives),
      .game_over   (game_over),
      .catch_pulse (catch_pulse),
      .miss_pulse  (miss_pulse)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive one frame of inputs, then sample 1 time unit after the next edge.
   task automatic step(input int bx, input int by, input int px, input int py, input int kc);
      bombX   = 10'(bx);
      bombY   = 10'(by);
      playerX = 10'(px);
      playerY = 10'(py);
      keycode = 8'(kc);
      @(posedge frame_clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input int pts, input int lv, input int ov,
                             input int cp, input int mp);
      check_eq({tag, ".points"}, int'(curPoints), pts);
      check_eq({tag, ".lives"}, int'(lives), lv);
      check_eq({tag, ".over"}, int'(game_over), ov);
      check_eq({tag, ".catch"}, int'(catch_pulse), cp);
      check_eq({tag, ".miss"}, int'(miss_pulse), mp);
   endtask

   initial begin
      Reset = 1'b1;
      bombX = 10'd370; bombY = 10'd240; playerX = 10'd100; playerY = 10'd400;
      keycode = 8'd0;
      repeat (2) @(posedge frame_clk);
      #1;
      check_outs("reset", 0, 3, 0, 0, 0);
      Reset = 1'b0;

      // Idle: bomb far from the player.
      for (int i = 0; i < 5; i++) step(370, 240, 100, 400, 0);
      check_outs("idle", 0, 3, 0, 0, 0);

      // Falling bomb over the player; first overlap at y=408.
      for (int y = 248; y <= 400; y += 8) begin
         step(370, y, 370, 420, 0);
         check_eq("pre_catch", int'(catch_pulse), 0);
      end
      step(370, 408, 370, 420, 0);
      check_outs("catch1", 1, 3, 0, 1, 0);
      for (int y = 416; y <= 472; y += 8) begin
         step(370, y, 370, 420, 0);
         check_outs("no_rescore", 1, 3, 0, 0, 0);
      end
      step(370, 476, 370, 420, 0);
      check_outs("no_rescore476", 1, 3, 0, 0, 0);
      step(370, 240, 370, 420, 0);   // respawn re-arms

      // Three misses down to game over.
      step(370, 479, 100, 400, 0);
      check_outs("miss1", 1, 2, 0, 0, 1);
      step(370, 479, 100, 400, 0);
      check_outs("miss1_hold", 1, 2, 0, 0, 0);
      step(370, 240, 100, 400, 0);
      step(370, 479, 100, 400, 0);
      check_outs("miss2", 1, 1, 0, 0, 1);
      step(370, 240, 100, 400, 0);
      step(370, 479, 100, 400, 0);
      check_outs("miss3", 1, 0, 1, 0, 1);
      step(370, 240, 100, 400, 0);
      step(370, 479, 100, 400, 0);
      check_outs("over_frozen", 1, 0, 1, 0, 0);

      // Restart lands in WAIT: overlap and floor ignored until respawn.
      step(370, 300, 100, 400, 8'h28);
      check_outs("restart", 0, 3, 0, 0, 0);
      step(370, 479, 370, 470, 0);
      check_outs("wait_ignore", 0, 3, 0, 0, 0);
      step(370, 200, 100, 400, 0);
      check_outs("wait_respawn", 0, 3, 0, 0, 0);
      step(370, 479, 370, 475, 0);
      check_outs("catch_vs_floor", 1, 3, 0, 1, 0);

      // Saturation at 9 points.
      for (int i = 0; i < 8; i++) begin
         step(370, 200, 100, 400, 0);
         step(370, 240, 370, 240, 0);
         check_eq("sat_catch", int'(catch_pulse), 1);
      end
      check_eq("points9", int'(curPoints), 9);
      step(370, 200, 100, 400, 0);
      step(370, 240, 370, 240, 0);
      check_outs("saturated", 9, 3, 0, 1, 0);

      // Overlap boundaries and wrap hazards.
      step(2, 200, 100, 400, 0);
      step(2, 240, 630, 240, 0);
      check_eq("wrap630", int'(catch_pulse), 0);
      step(2, 240, 1010, 240, 0);
      check_eq("wrap1010", int'(catch_pulse), 0);
      step(391, 240, 370, 240, 0);
      check_eq("dx21", int'(catch_pulse), 0);
      step(390, 253, 370, 240, 0);
      check_eq("dy13", int'(catch_pulse), 0);
      step(390, 252, 370, 240, 0);
      check_outs("edge_catch", 9, 3, 0, 1, 0);
      step(2, 100, 100, 400, 0);
      step(2, 240, 22, 240, 0);
      check_eq("dx_neg20", int'(catch_pulse), 1);

      // Build 5 points, then reset mid-frame while in WAIT.
      Reset = 1'b1;
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step(370, 200, 100, 400, 0);
         step(370, 240, 370, 240, 0);
      end
      check_outs("pts5", 5, 3, 0, 1, 0);
      #3;
      Reset = 1'b1;
      #1;
      check_outs("async_reset", 0, 3, 0, 0, 0);
      Reset = 1'b0;
      step(370, 240, 370, 240, 0);
      check_outs("post_reset_armed", 1, 3, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
